dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 14 +
 rtl/byte_lane_unit.sv | 26 ++
 rtl/dmem_responder.sv | 72 +++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, funct3 access-size constants and access legality check
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  // True for reserved encodings, sign-variant stores and misaligned halves/words
  function automatic logic bad_access(input logic [2:0] f, input logic w, input logic [1:0] off);
    return (f == 3'b011) | (f[2:1] == 2'b11) | (w & f[2]) | ((f[1:0] == 2'b01) & off[0])
         | ((f == LS_W) & (off != 2'b00));
  endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: load lane extraction/extension and store byte-merge
module byte_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wd,
  output logic [31:0] ld,
  output logic [31:0] st
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b  = word[{off, 3'b000} +: 8];
    h  = off[1] ? word[31:16] : word[15:0];
    ld = funct3 == LS_B  ? {{24{b[7]}}, b} :
         funct3 == LS_BU ? {24'b0, b} :
         funct3 == LS_H  ? {{16{h[15]}}, h} :
         funct3 == LS_HU ? {16'b0, h} : word;
    st = word;
    if (funct3[1:0] == 2'b00) st[{off, 3'b000} +: 8] = wd[7:0];
    else if (funct3[1:0] == 2'b01) st[{off[1], 4'b0000} +: 16] = wd[15:0];
    else st = wd;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed wait-state latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);
  state_t state, state_nx;
  logic [3:0]  cnt;
  logic        q_we, s_we, accept, enter_resp, s_err;
  logic [2:0]  q_f3, s_f3;
  logic [31:0] q_a, q_wd, s_a, s_wd, word, ld, st;
  logic [31:0] mem [DEPTH_WORDS];
  assign accept = req & ready;
  // With zero wait states the commit happens on the accept edge, before capture
  assign s_we = state == S_IDLE ? we     : q_we;
  assign s_f3 = state == S_IDLE ? funct3 : q_f3;
  assign s_a  = state == S_IDLE ? a      : q_a;
  assign s_wd = state == S_IDLE ? wd     : q_wd;
  assign word  = mem[s_a[IW+1:2]];
  assign s_err = bad_access(s_f3, s_we, s_a[1:0]) | (s_a[31:2] >= DEPTH30);
  assign enter_resp = (state == S_IDLE & accept & WAIT_CYCLES == 0) | (state == S_WAIT & cnt == 4'd1);
  byte_lane_unit u_lane (.funct3(s_f3), .off(s_a[1:0]), .word(word), .wd(s_wd), .ld(ld), .st(st));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      q_we  <= 1'b0;
      q_f3  <= '0;
      q_a   <= '0;
      q_wd  <= '0;
      rd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= accept ? 4'(WAIT_CYCLES) : (state == S_WAIT ? cnt - 4'd1 : cnt);
      if (accept) begin
        q_we <= we;
        q_f3 <= funct3;
        q_a  <= a;
        q_wd <= wd;
      end
      if (enter_resp) begin
        err <= s_err;
        if (!s_we) rd <= s_err ? '0 : ld;
      end
    end
  // Array is deliberately not reset; writes are blocked while reset is held
  always_ff @(posedge clk)
    if (reset & enter_resp & s_we & !s_err) mem[s_a[IW+1:2]] <= st;
  always_comb
    state_nx = state == S_IDLE ? (accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
               state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
  always_comb begin
    ready  = state == S_IDLE;
    rvalid = state == S_RESP;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a 2-wait-state and a 0-wait-state responder
module tb_dmem_responder;
  import dmem_pkg::*;
  logic clk = 1'b0, reset = 1'b0, req2 = 1'b0, req0 = 1'b0, we = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] a = '0, wd = '0;
  logic ready2, rvalid2, err2, ready0, rvalid0, err0;
  logic [31:0] rd2, rd0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) u2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .funct3(funct3), .a(a), .wd(wd),
    .ready(ready2), .rvalid(rvalid2), .rd(rd2), .err(err2));
  dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .funct3(funct3), .a(a), .wd(wd),
    .ready(ready0), .rvalid(rvalid0), .rd(rd0), .err(err0));

  // One transaction on u2; lat counts edges from (and including) the accept edge
  task automatic do2(input logic w, input logic [2:0] f, input logic [31:0] addr, input logic [31:0] data,
                     output int lat, output logic [31:0] r, output logic e);
    lat = 99;
    r = 'x;
    e = 1'bx;
    @(negedge clk);
    we = w; funct3 = f; a = addr; wd = data; req2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      req2 = 1'b0;
      if (rvalid2) begin
        lat = i; r = rd2; e = err2;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready2); end
    total++; if (rvalid2 !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", rvalid2); end
    total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL reset_rd got %h want 0", rd2); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err2); end
    total++; if (ready0 !== 1'b1 || rvalid0 !== 1'b0) begin bad++; $display("FAIL reset_u0 got ready=%b rvalid=%b want 1/0", ready0, rvalid0); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word;
    int lat; logic [31:0] r; logic e;
    do2(1'b1, LS_W, 32'h64, 32'h19, lat, r, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got %0d want 3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sw_err got %b want 0", e); end
    do2(1'b0, LS_W, 32'h64, 32'h0, lat, r, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got %0d want 3", lat); end
    total++; if (r !== 32'h19 || e !== 1'b0) begin bad++; $display("FAIL lw_data got %h/%b want 00000019/0", r, e); end
    total++; if (rd2 !== 32'h19) begin bad++; $display("FAIL rd_hold got %h want 00000019", rd2); end
  endtask

  task automatic test_byte;
    int lat; logic [31:0] r; logic e;
    do2(1'b1, LS_W, 32'h10, 32'h11223344, lat, r, e);
    do2(1'b1, LS_B, 32'h12, 32'h000000AB, lat, r, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_err got %b want 0", e); end
    do2(1'b0, LS_W, 32'h10, 32'h0, lat, r, e);
    total++; if (r !== 32'h11AB3344) begin bad++; $display("FAIL sb_merge got %h want 11ab3344", r); end
    do2(1'b0, LS_B, 32'h12, 32'h0, lat, r, e);
    total++; if (r !== 32'hFFFFFFAB) begin bad++; $display("FAIL lb got %h want ffffffab", r); end
    do2(1'b0, LS_BU, 32'h12, 32'h0, lat, r, e);
    total++; if (r !== 32'h000000AB) begin bad++; $display("FAIL lbu got %h want 000000ab", r); end
    do2(1'b0, LS_B, 32'h13, 32'h0, lat, r, e);
    total++; if (r !== 32'h00000011) begin bad++; $display("FAIL lb_lane3 got %h want 00000011", r); end
  endtask

  task automatic test_half;
    int lat; logic [31:0] r; logic e;
    do2(1'b1, LS_H, 32'h22, 32'h00008001, lat, r, e);
    do2(1'b0, LS_H, 32'h22, 32'h0, lat, r, e);
    total++; if (r !== 32'hFFFF8001) begin bad++; $display("FAIL lh got %h want ffff8001", r); end
    do2(1'b0, LS_HU, 32'h22, 32'h0, lat, r, e);
    total++; if (r !== 32'h00008001) begin bad++; $display("FAIL lhu got %h want 00008001", r); end
    do2(1'b0, LS_W, 32'h21, 32'h0, lat, r, e);
    total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL lw_misalign got %h/%b want 00000000/1", r, e); end
    do2(1'b1, LS_H, 32'h23, 32'h00001234, lat, r, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sh_misalign_err got %b want 1", e); end
    do2(1'b0, LS_HU, 32'h22, 32'h0, lat, r, e);
    total++; if (r !== 32'h00008001 || e !== 1'b0) begin bad++; $display("FAIL sh_misalign_nowrite got %h/%b want 00008001/0", r, e); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] r; logic e;
    do2(1'b1, LS_BU, 32'h64, 32'hFFFFFFFF, lat, r, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sbu_err got %b want 1", e); end
    do2(1'b0, LS_W, 32'h64, 32'h0, lat, r, e);
    total++; if (r !== 32'h19 || e !== 1'b0) begin bad++; $display("FAIL sbu_nowrite got %h/%b want 00000019/0", r, e); end
    do2(1'b0, LS_W, 32'h400, 32'h0, lat, r, e);
    total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL lw_range got %h/%b want 00000000/1", r, e); end
    do2(1'b1, LS_W, 32'h0, 32'h00000005, lat, r, e);
    do2(1'b1, LS_W, 32'h400, 32'h0000DEAD, lat, r, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_range_err got %b want 1", e); end
    do2(1'b0, LS_W, 32'h0, 32'h0, lat, r, e);
    total++; if (r !== 32'h5) begin bad++; $display("FAIL sw_range_nowrite got %h want 00000005", r); end
    do2(1'b0, 3'b011, 32'h0, 32'h0, lat, r, e);
    total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL f3_011 got %h/%b want 00000000/1", r, e); end
    do2(1'b0, 3'b110, 32'h0, 32'h0, lat, r, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL f3_110 got %b want 1", e); end
    do2(1'b0, LS_W, 32'h0, 32'h0, lat, r, e);
    total++; if (e !== 1'b0 || r !== 32'h5) begin bad++; $display("FAIL err_clear got %h/%b want 00000005/0", r, e); end
  endtask

  task automatic test_back_to_back0;
    int pulses = 0;
    @(negedge clk);
    we = 1'b0; funct3 = LS_W; a = 32'h0; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rvalid0) pulses++;
      total++; if (rvalid0 !== (i % 2 == 0)) begin bad++; $display("FAIL b2b_rvalid[%0d] got %b want %b", i, rvalid0, i % 2 == 0); end
      total++; if (ready0 !== (i % 2 != 0)) begin bad++; $display("FAIL b2b_ready[%0d] got %b want %b", i, ready0, i % 2 != 0); end
    end
    req0 = 1'b0;
    total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_accepts got %0d want 3", pulses); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] r; logic e;
    @(negedge clk);
    we = 1'b1; funct3 = LS_W; a = 32'h64; wd = 32'h00000BAD; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    total++; if (ready2 !== 1'b0) begin bad++; $display("FAIL abort_busy got ready=%b want 0", ready2); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++; if (ready2 !== 1'b1 || rvalid2 !== 1'b0) begin bad++; $display("FAIL abort_state got ready=%b rvalid=%b want 1/0", ready2, rvalid2); end
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (rvalid2 !== 1'b0) begin bad++; $display("FAIL abort_rvalid got %b want 0", rvalid2); end
    end
    @(negedge clk);
    reset = 1'b1;
    do2(1'b0, LS_W, 32'h64, 32'h0, lat, r, e);
    total++; if (r !== 32'h19 || e !== 1'b0) begin bad++; $display("FAIL abort_nowrite got %h/%b want 00000019/0", r, e); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back0();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
